// File: rtl/adder_arb_pkg.sv
// Shared types and default sizes for the adder arbiter.
//   ADDER_WIDTH  : default operand/sum width
//   ADDER_STAGES : default adder latency (register layers incl. input layer)
//   req_id_t     : requester index (0 = ALU, 1 = address/PC generator)
//   tag_t        : in-flight operation tag {valid, id}
//   rsp_t        : response payload {sum, cout}
package adder_arb_pkg;

  localparam int unsigned ADDER_WIDTH  = 32;
  localparam int unsigned ADDER_STAGES = 4;

  typedef logic req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

  typedef struct packed {
    logic [ADDER_WIDTH-1:0] sum;
    logic                   cout;
  } rsp_t;

endpackage

// File: rtl/rsp_fifo.sv
// Synchronous response FIFO, registered head, no bypass of a same-cycle push.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   push, din  : write request and data (ignored when full)
//   pop        : read request (ignored when empty)
//   dout       : head-of-FIFO data
//   full/empty : occupancy flags
module rsp_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 33
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push_en;
  logic          pop_en;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointer increment with wrap for non-power-of-two depths
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop_en) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      count <= count + CW'(push_en) - CW'(pop_en);
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one pipelined adder between requester 0 (ALU) and requester 1
// (address/PC generator). One grant per cycle; a tag pipeline matched to the
// adder latency routes each result into its owner's response FIFO. Credits
// bound in-flight + queued results per requester so the unstallable adder
// can never overflow a FIFO.
// Build option: define ADDER_ARB_FIXED_PRIO_EN for fixed priority
// (requester 0 wins); default build is round-robin.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   reqN_valid/ready/a/b/cin       : request handshake and operands (N=0,1)
//   adder_a/b/cin, adder_issue     : adder input layer drive
//   adder_sum, adder_cout          : adder result, STAGES cycles after issue
//   rspN_valid/ready/sum/cout      : response FIFO head and pop handshake
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int unsigned WIDTH     = ADDER_WIDTH,
  parameter int unsigned STAGES    = ADDER_STAGES,
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic [WIDTH-1:0] adder_a,
  output logic [WIDTH-1:0] adder_b,
  output logic             adder_cin,
  output logic             adder_issue,
  input  logic [WIDTH-1:0] adder_sum,
  input  logic             adder_cout,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_sum,
  output logic             rsp0_cout,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_sum,
  output logic             rsp1_cout
);

  localparam int unsigned CW = $clog2(RSP_DEPTH + 1);
  localparam int unsigned DW = WIDTH + 1;

  logic [CW-1:0] credit0;
  logic [CW-1:0] credit1;
  logic          elig0;
  logic          elig1;
  logic          gnt0;
  logic          gnt1;
  tag_t          tags [STAGES];
  tag_t          tag_out;
  logic          push0;
  logic          push1;
  logic          pop0;
  logic          pop1;
  logic          full0;
  logic          full1;
  logic          empty0;
  logic          empty1;
  logic [DW-1:0] dout0;
  logic [DW-1:0] dout1;

  assign elig0 = req0_valid && (credit0 != '0);
  assign elig1 = req1_valid && (credit1 != '0);

`ifdef ADDER_ARB_FIXED_PRIO_EN
  // Fixed priority: requester 0 wins whenever eligible
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      gnt0 = elig0;
      gnt1 = elig1 && !elig0;
    end
  end
`else
  logic last_grant;

  // Round-robin: on a tie, grant the requester that did not win last
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (elig0 && elig1) begin
        gnt0 = last_grant;
        gnt1 = !last_grant;
      end else begin
        gnt0 = elig0;
        gnt1 = elig1;
      end
    end
  end

  // Pointer reset to 1 so requester 0 wins the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (gnt0 || gnt1) begin
      last_grant <= gnt1;
    end
  end
`endif

  assign req0_ready  = gnt0;
  assign req1_ready  = gnt1;
  assign adder_issue = gnt0 || gnt1;

  // Operand mux to the adder input layer; zero when idle
  always_comb begin
    adder_a   = '0;
    adder_b   = '0;
    adder_cin = 1'b0;
    if (gnt0) begin
      adder_a   = req0_a;
      adder_b   = req0_b;
      adder_cin = req0_cin;
    end else if (gnt1) begin
      adder_a   = req1_a;
      adder_b   = req1_b;
      adder_cin = req1_cin;
    end
  end

  // Owner tags travel alongside the adder pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      tags <= '{default: '0};
    end else begin
      tags[0] <= {adder_issue, gnt1};
      for (int unsigned i = 1; i < STAGES; i++) begin
        tags[i] <= tags[i-1];
      end
    end
  end

  assign tag_out = tags[STAGES-1];
  assign push0   = tag_out.valid && (tag_out.id == 1'b0) && !full0;
  assign push1   = tag_out.valid && (tag_out.id == 1'b1) && !full1;
  assign pop0    = rsp0_valid && rsp0_ready;
  assign pop1    = rsp1_valid && rsp1_ready;

  // Credits: spent on issue, returned on pop
  always_ff @(posedge clk) begin
    if (rst) begin
      credit0 <= CW'(RSP_DEPTH);
      credit1 <= CW'(RSP_DEPTH);
    end else begin
      credit0 <= credit0 - CW'(gnt0) + CW'(pop0);
      credit1 <= credit1 - CW'(gnt1) + CW'(pop1);
    end
  end

  rsp_fifo #(.DEPTH(RSP_DEPTH), .DW(DW)) u_rsp_fifo0 (
    .clk   (clk),
    .rst   (rst),
    .push  (push0),
    .din   ({adder_sum, adder_cout}),
    .pop   (pop0),
    .dout  (dout0),
    .full  (full0),
    .empty (empty0)
  );

  rsp_fifo #(.DEPTH(RSP_DEPTH), .DW(DW)) u_rsp_fifo1 (
    .clk   (clk),
    .rst   (rst),
    .push  (push1),
    .din   ({adder_sum, adder_cout}),
    .pop   (pop1),
    .dout  (dout1),
    .full  (full1),
    .empty (empty1)
  );

  assign rsp0_valid             = !empty0;
  assign rsp1_valid             = !empty1;
  assign {rsp0_sum, rsp0_cout}  = dout0;
  assign {rsp1_sum, rsp1_cout}  = dout1;

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: a pipelined adder model drives
// adder_sum, a queue-based reference predicts grants, adder drive and
// responses every cycle, and directed sequences pin hand-computed results.
// Honours ADDER_ARB_FIXED_PRIO_EN to match the fixed-priority build.
module tb_adder_arbiter;
  import adder_arb_pkg::*;

  localparam int unsigned W  = ADDER_WIDTH;
  localparam int unsigned W1 = W + 1;
  localparam int unsigned S  = ADDER_STAGES;
  localparam int          D  = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req0_cin;
  logic         req1_valid, req1_ready, req1_cin;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [W-1:0] adder_a, adder_b, adder_sum;
  logic         adder_cin, adder_issue, adder_cout;
  logic         rsp0_valid, rsp0_ready, rsp0_cout;
  logic         rsp1_valid, rsp1_ready, rsp1_cout;
  logic [W-1:0] rsp0_sum, rsp1_sum;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  adder_arbiter #(.WIDTH(W), .STAGES(S), .RSP_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin), .adder_issue(adder_issue),
    .adder_sum(adder_sum), .adder_cout(adder_cout),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_sum(rsp0_sum), .rsp0_cout(rsp0_cout),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_sum(rsp1_sum), .rsp1_cout(rsp1_cout)
  );

  // Pipelined adder: S register layers; garbage when idle so stale results are visible
  logic [W:0] pipe [S];
  always @(posedge clk) begin
    if (adder_issue) pipe[0] <= {1'b0, adder_a} + {1'b0, adder_b} + W1'(adder_cin);
    else             pipe[0] <= {1'($urandom), W'($urandom)};
    for (int i = 1; i < S; i++) pipe[i] <= pipe[i-1];
  end
  assign {adder_cout, adder_sum} = pipe[S-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: credits, pointer, in-flight list with due edge, response queues
  typedef struct {
    int         id;
    int         due;
    logic [W:0] res;
  } fl_t;

  fl_t        infl[$];
  logic [W:0] q0[$];
  logic [W:0] q1[$];
  int         cr0  = D;
  int         cr1  = D;
  int         last = 1;
  int         ecnt = 0;

  function automatic int pick(input bit e0, input bit e1);
`ifdef ADDER_ARB_FIXED_PRIO_EN
    if (e0) return 0;
    if (e1) return 1;
    return -1;
`else
    if (e0 && e1) return (last == 0) ? 1 : 0;
    if (e0) return 0;
    if (e1) return 1;
    return -1;
`endif
  endfunction

  // Compare DUT against the model, then advance the model across the coming edge
  always @(negedge clk) begin
    bit         e0, e1;
    int         g, sz0, sz1;
    logic [W-1:0] ea, eb;
    logic       ec;
    fl_t        f;

    e0 = !rst && req0_valid && (cr0 > 0);
    e1 = !rst && req1_valid && (cr1 > 0);
    g  = rst ? -1 : pick(e0, e1);
    ea = (g == 0) ? req0_a   : (g == 1) ? req1_a   : '0;
    eb = (g == 0) ? req0_b   : (g == 1) ? req1_b   : '0;
    ec = (g == 0) ? req0_cin : (g == 1) ? req1_cin : 1'b0;

    chk("req0_ready", 64'(req0_ready), 64'(g == 0));
    chk("req1_ready", 64'(req1_ready), 64'(g == 1));
    chk("adder_issue", 64'(adder_issue), 64'(g >= 0));
    chk("adder_a", 64'(adder_a), 64'(ea));
    chk("adder_b", 64'(adder_b), 64'(eb));
    chk("adder_cin", 64'(adder_cin), 64'(ec));
    chk("rsp0_valid", 64'(rsp0_valid), 64'(q0.size() != 0));
    chk("rsp1_valid", 64'(rsp1_valid), 64'(q1.size() != 0));
    if (q0.size() != 0) chk("rsp0_data", 64'({rsp0_cout, rsp0_sum}), 64'(q0[0]));
    if (q1.size() != 0) chk("rsp1_data", 64'({rsp1_cout, rsp1_sum}), 64'(q1[0]));

    ecnt++;
    if (rst) begin
      q0.delete(); q1.delete(); infl.delete();
      cr0 = D; cr1 = D; last = 1;
    end else begin
      sz0 = q0.size();
      sz1 = q1.size();
      if (sz0 > 0 && rsp0_ready) begin void'(q0.pop_front()); cr0++; end
      if (sz1 > 0 && rsp1_ready) begin void'(q1.pop_front()); cr1++; end
      if (infl.size() > 0 && infl[0].due == ecnt) begin
        f = infl.pop_front();
        if (f.id == 0) begin chk("fifo0_no_overflow", 64'(sz0 >= D), 64'(0)); q0.push_back(f.res); end
        else           begin chk("fifo1_no_overflow", 64'(sz1 >= D), 64'(0)); q1.push_back(f.res); end
      end
      if (g >= 0) begin
        f.id  = g;
        f.due = ecnt + int'(S);
        f.res = (g == 0) ? ({1'b0, req0_a} + {1'b0, req0_b} + W1'(req0_cin))
                         : ({1'b0, req1_a} + {1'b0, req1_b} + W1'(req1_cin));
        infl.push_back(f);
        if (g == 0) cr0--; else cr1--;
        last = g;
      end
    end
  end

  // Snapshot of outputs at the falling edge, then step past the next rising edge
  logic         s_rdy0, s_rdy1, s_rv0, s_rv1, s_rc0, s_pop0, s_pop1, acc0, acc1;
  logic [W-1:0] s_rs0;

  task automatic tick();
    @(negedge clk);
    s_rdy0 = req0_ready;  s_rdy1 = req1_ready;
    s_rv0  = rsp0_valid;  s_rv1  = rsp1_valid;
    s_rs0  = rsp0_sum;    s_rc0  = rsp0_cout;
    acc0   = req0_valid && req0_ready;
    acc1   = req1_valid && req1_ready;
    s_pop0 = rsp0_valid && rsp0_ready;
    s_pop1 = rsp1_valid && rsp1_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic new_ops0();
    req0_a = $urandom; req0_b = $urandom; req0_cin = 1'($urandom_range(1));
  endtask

  task automatic new_ops1();
    req1_a = $urandom; req1_b = $urandom; req1_cin = 1'($urandom_range(1));
  endtask

`ifdef ADDER_ARB_FIXED_PRIO_EN
  int exp_tie [8] = '{0, 0, 0, 0, 1, 1, 0, 0};
  localparam int EXP_C0 = 6;
  localparam int EXP_C1 = 2;
`else
  int exp_tie [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
  localparam int EXP_C0 = 4;
  localparam int EXP_C1 = 4;
`endif

  initial begin
    int got, lat, n, c0, c1, preq, prsp;
    bit any1, anyv;

    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // Reset: ready held low even with a valid request
    repeat (3) begin
      tick();
      chk("rst_ready0", 64'(s_rdy0), 64'(0));
    end
    chk("rst_rsp0_valid", 64'(s_rv0), 64'(0));
    chk("rst_rsp0_sum", 64'(s_rs0), 64'(0));
    chk("rst_rsp0_cout", 64'(s_rc0), 64'(0));

    // Tie alternation straight out of reset
    rst = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    new_ops0(); new_ops1();
    c0 = 0; c1 = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      got = s_rdy0 ? 0 : (s_rdy1 ? 1 : -1);
      chk("tie_grant", 64'(got), 64'(exp_tie[i]));
      if (acc0) new_ops0();
      if (acc1) new_ops1();
      c0 += int'(s_pop0); c1 += int'(s_pop1);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (20) begin
      tick();
      c0 += int'(s_pop0); c1 += int'(s_pop1);
    end
    chk("tie_rsp0_count", 64'(c0), 64'(EXP_C0));
    chk("tie_rsp1_count", 64'(c1), 64'(EXP_C1));

    // Single op: 0xFFFFFFFF + 1 -> sum 0, cout 1, five cycles after accept
    req0_valid = 1'b1; req0_a = 32'hFFFF_FFFF; req0_b = 32'h1; req0_cin = 1'b0;
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      tick();
      if (acc0) got = 1;
    end
    chk("single_accept", 64'(got), 64'(1));
    req0_valid = 1'b0;
    lat = 0; any1 = 1'b0;
    for (int i = 1; i <= 12 && lat == 0; i++) begin
      tick();
      if (s_rv1) any1 = 1'b1;
      if (s_rv0) begin
        lat = i;
        chk("single_sum", 64'(s_rs0), 64'(32'h0));
        chk("single_cout", 64'(s_rc0), 64'(1));
      end
    end
    chk("single_latency", 64'(lat), 64'(5));
    chk("single_rsp1_idle", 64'(any1), 64'(0));

    // Credit stall: consumer 0 blocked
    repeat (10) tick();
    rsp0_ready = 1'b0; req0_valid = 1'b1; new_ops0();
    n = 0;
    repeat (10) begin
      tick();
      if (acc0) begin n++; new_ops0(); end
    end
    chk("stall_accepts", 64'(n), 64'(4));
    chk("stall_ready_low", 64'(s_rdy0), 64'(0));
    rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
    n = int'(acc0);
    repeat (9) begin
      tick();
      if (acc0) begin n++; new_ops0(); end
    end
    chk("stall_one_more", 64'(n), 64'(1));

    // Issue and pop together at credit 1 keeps the credit at 1
    req0_valid = 1'b0; rsp0_ready = 1'b1;
    tick();
    chk("pop_full_fifo", 64'(s_pop0), 64'(1));
    req0_valid = 1'b1; new_ops0();
    tick();
    chk("simul_ready", 64'(s_rdy0), 64'(1));
    chk("simul_pop", 64'(s_pop0), 64'(1));
    rsp0_ready = 1'b0;
    if (acc0) new_ops0();
    tick();
    chk("simul_credit_kept", 64'(s_rdy0), 64'(1));
    if (acc0) new_ops0();
    tick();
    chk("credit_exhausted", 64'(s_rdy0), 64'(0));
    req0_valid = 1'b0;

    // Reset with operations in flight
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (15) tick();
    req0_valid = 1'b1; new_ops0();
    n = 0;
    for (int i = 0; i < 10 && n < 3; i++) begin
      tick();
      if (acc0) begin n++; new_ops0(); end
    end
    chk("midrst_issued", 64'(n), 64'(3));
    req0_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    anyv = 1'b0;
    repeat (15) begin
      tick();
      anyv = anyv | s_rv0 | s_rv1;
    end
    chk("midrst_flushed", 64'(anyv), 64'(0));
    rsp0_ready = 1'b0; req0_valid = 1'b1; new_ops0();
    n = 0;
    repeat (10) begin
      tick();
      if (acc0) begin n++; new_ops0(); end
    end
    chk("midrst_credits", 64'(n), 64'(4));

    // Randomized traffic with occasional resets
    req0_valid = 1'b0;
    preq = 50; prsp = 50;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (i % 500 == 0) begin
        preq = 30 + 35 * int'($urandom_range(2));
        prsp = 20 + 40 * int'($urandom_range(2));
      end
      rst = ($urandom_range(399) == 0);
      if (!req0_valid || acc0) begin req0_valid = ($urandom_range(99) < preq); new_ops0(); end
      if (!req1_valid || acc1) begin req1_valid = ($urandom_range(99) < preq); new_ops1(); end
      rsp0_ready = ($urandom_range(99) < prsp);
      rsp1_ready = ($urandom_range(99) < prsp);
    end

    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (30) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks %0d failures", n_checks, n_fail);
    $fatal(1);
  end

endmodule
